// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake, status flags and RAM-port bundle for ram_fifo_ctrl.
// slave = the controller; master = user logic plus the attached synchronous RAM.
interface ram_fifo_ctrl_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth) + 1;

  logic             pushEn;
  logic [width-1:0] pushData;
  logic             popEn;
  logic [width-1:0] popData;
  logic             popValid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             almostFull;
  logic             almostEmpty;

  logic             ramWrEn;
  logic [width-1:0] ramWrData;
  logic [AW-1:0]    ramWrAdress;
  logic             ramRdEn;
  logic [AW-1:0]    ramRdAdress;
  logic [width-1:0] ramRdData;

  modport slave (
    input  pushEn, pushData, popEn, ramRdData,
    output popData, popValid, full, empty, count, overflow, underflow,
           almostFull, almostEmpty,
           ramWrEn, ramWrData, ramWrAdress, ramRdEn, ramRdAdress
  );

  modport master (
    output pushEn, pushData, popEn, ramRdData,
    input  popData, popValid, full, empty, count, overflow, underflow,
           almostFull, almostEmpty,
           ramWrEn, ramWrData, ramWrAdress, ramRdEn, ramRdAdress
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external synchronous RAM; RAM_FIFO_ALMOST_EN enables almostFull/almostEmpty.
// Pop data is valid one cycle after an accepted pop; requests against full/empty are dropped and flagged.
module ram_fifo_ctrl #(
  parameter int width    = 8,
  parameter int depth    = 16,
  parameter int AF_LEVEL = depth - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_fifo_ctrl_if.slave fifo
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(depth);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_valid;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  // Flags come only from the registered count, so they never depend on this cycle's requests.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Qualifying with rst_n keeps the RAM strobes low while reset is held.
  assign push_ok = rst_n && fifo.pushEn && !full;
  assign pop_ok  = rst_n && fifo.popEn  && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pop_valid <= pop_ok;
      overflow  <= fifo.pushEn && full;
      underflow <= fifo.popEn && empty;
    end
  end

  assign fifo.ramWrEn     = push_ok;
  assign fifo.ramWrData   = fifo.pushData;
  assign fifo.ramWrAdress = wr_ptr;
  assign fifo.ramRdEn     = pop_ok;
  assign fifo.ramRdAdress = rd_ptr;

  assign fifo.popData   = fifo.ramRdData;
  assign fifo.popValid  = pop_valid;
  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.count     = count;
  assign fifo.overflow  = overflow;
  assign fifo.underflow = underflow;

`ifdef RAM_FIFO_ALMOST_EN
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);
  assign fifo.almostFull  = (count >= AF_CNT);
  assign fifo.almostEmpty = (count <= AE_CNT);
`else
  assign fifo.almostFull  = 1'b0;
  assign fifo.almostEmpty = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (width 8, depth 16) with a synchronous RAM model and data scoreboard.
module tb_ram_fifo_ctrl;
  localparam int W = 8;
  localparam int D = 16;
`ifdef RAM_FIFO_ALMOST_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.width(W), .depth(D)) bus ();
  ram_fifo_ctrl #(.width(W), .depth(D)) dut (.clk(clk), .rst_n(rst_n), .fifo(bus));

  // Attached synchronous RAM
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (bus.ramWrEn) mem[bus.ramWrAdress] <= bus.ramWrData;
    if (bus.ramRdEn) bus.ramRdData <= mem[bus.ramRdAdress];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int m_count = 0;
  int m_wp = 0;
  int m_rp = 0;
  bit m_vld = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  // Cycle monitor: registered outputs, RAM strobes and scoreboard data against the reference model
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      n_cmp++;
      if (bus.popValid !== m_vld) begin n_bad++; $display("FAIL mon_popValid got %b want %b t=%0t", bus.popValid, m_vld, $time); end
      if (m_vld) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL sb_underrun got data %h want none t=%0t", bus.popData, $time);
        end else begin
          sb_exp = exp_q.pop_front();
          if (bus.popData !== sb_exp) begin n_bad++; $display("FAIL sb_data got %h want %h t=%0t", bus.popData, sb_exp, $time); end
        end
      end
      n_cmp++;
      if (bus.count !== 5'(m_count)) begin n_bad++; $display("FAIL mon_count got %0d want %0d t=%0t", bus.count, m_count, $time); end
      n_cmp++;
      if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
        n_bad++; $display("FAIL mon_ovf_unf got %b%b want %b%b t=%0t", bus.overflow, bus.underflow, m_ovf, m_unf, $time);
      end
      n_cmp++;
      if (bus.full !== (m_count == D) || bus.empty !== (m_count == 0)) begin
        n_bad++; $display("FAIL mon_flags got full=%b empty=%b want count=%0d t=%0t", bus.full, bus.empty, m_count, $time);
      end
      n_cmp++;
      if (bus.ramWrAdress !== 4'(m_wp) || bus.ramRdAdress !== 4'(m_rp)) begin
        n_bad++; $display("FAIL mon_addr got wr=%0d rd=%0d want wr=%0d rd=%0d t=%0t", bus.ramWrAdress, bus.ramRdAdress, m_wp, m_rp, $time);
      end
      n_cmp++;
      if (bus.ramWrEn !== (bus.pushEn && m_count != D) || bus.ramRdEn !== (bus.popEn && m_count != 0)) begin
        n_bad++; $display("FAIL mon_ram_en got wr=%b rd=%b want count=%0d push=%b pop=%b t=%0t", bus.ramWrEn, bus.ramRdEn, m_count, bus.pushEn, bus.popEn, $time);
      end
    end
  end

  task automatic drive(input logic p, input logic [W-1:0] d, input logic q);
    bus.pushEn = p; bus.pushData = d; bus.popEn = q;
  endtask

  task automatic tick();
    bit ap, ar;
    ap = bus.pushEn && (m_count != D);
    ar = bus.popEn && (m_count != 0);
    @(posedge clk);
    if (ap) begin exp_q.push_back(bus.pushData); m_wp = (m_wp + 1) % D; end
    if (ar) m_rp = (m_rp + 1) % D;
    m_count = m_count + int'(ap) - int'(ar);
    m_ovf = bus.pushEn && !ap;
    m_unf = bus.popEn && !ar;
    m_vld = ar;
    #1;
  endtask

  task automatic cycle(input logic p, input logic [W-1:0] d, input logic q);
    drive(p, d, q);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 8'h11, 1'b1);
    #3;
    n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_state got count=%0d empty=%b full=%b want 0 1 0", bus.count, bus.empty, bus.full); end
    n_cmp++; if (bus.popValid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b%b%b want 000", bus.popValid, bus.overflow, bus.underflow); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.ramWrEn !== 1'b0 || bus.ramRdEn !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en got wr=%b rd=%b want 0 0", bus.ramWrEn, bus.ramRdEn); end
    n_cmp++; if (bus.almostEmpty !== ALM || bus.almostFull !== 1'b0) begin n_bad++; $display("FAIL reset_almost got ae=%b af=%b want %b 0", bus.almostEmpty, bus.almostFull, ALM); end
    n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL reset_hold_count got %0d want 0", bus.count); end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b0); #2;
    n_cmp++; if (bus.ramWrEn !== 1'b1 || bus.ramWrAdress !== 4'd0 || bus.ramWrData !== 8'hA5) begin n_bad++; $display("FAIL single_write got en=%b addr=%0d data=%h want 1 0 a5", bus.ramWrEn, bus.ramWrAdress, bus.ramWrData); end
    tick();
    n_cmp++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin n_bad++; $display("FAIL single_count1 got count=%0d empty=%b want 1 0", bus.count, bus.empty); end
    drive(1'b0, 8'h00, 1'b1); #2;
    n_cmp++; if (bus.ramRdEn !== 1'b1 || bus.ramRdAdress !== 4'd0) begin n_bad++; $display("FAIL single_read got en=%b addr=%0d want 1 0", bus.ramRdEn, bus.ramRdAdress); end
    tick();
    n_cmp++; if (bus.popValid !== 1'b1 || bus.popData !== 8'hA5) begin n_bad++; $display("FAIL single_pop got vld=%b data=%h want 1 a5", bus.popValid, bus.popData); end
    n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL single_count0 got count=%0d empty=%b want 0 1", bus.count, bus.empty); end
    cycle(1'b0, 8'h00, 1'b0);
    n_cmp++; if (bus.popValid !== 1'b0) begin n_bad++; $display("FAIL single_vld_pulse got %b want 0", bus.popValid); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < D; i++) cycle(1'b1, 8'(i), 1'b0);
    n_cmp++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin n_bad++; $display("FAIL fill_full got full=%b count=%0d want 1 16", bus.full, bus.count); end
    cycle(1'b1, 8'hFF, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin n_bad++; $display("FAIL fill_ovf got ovf=%b count=%0d want 1 16", bus.overflow, bus.count); end
    cycle(1'b0, 8'h00, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_once got %b want 0", bus.overflow); end
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.popValid !== 1'b1 || bus.popData !== 8'(i)) begin n_bad++; $display("FAIL drain_data got vld=%b data=%h want 1 %h", bus.popValid, bus.popData, 8'(i)); end
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < D; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    n_cmp++; if (bus.count !== 5'd15 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL fullpp_state got count=%0d ovf=%b want 15 1", bus.count, bus.overflow); end
    n_cmp++; if (bus.popValid !== 1'b1 || bus.popData !== 8'h20) begin n_bad++; $display("FAIL fullpp_pop got vld=%b data=%h want 1 20", bus.popValid, bus.popData); end
    cycle(1'b0, 8'h00, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b0 || bus.count !== 5'd15) begin n_bad++; $display("FAIL fullpp_after got ovf=%b count=%0d want 0 15", bus.overflow, bus.count); end
    for (int i = 1; i < D; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_underflow();
    logic [3:0] wa, ra;
    wa = bus.ramWrAdress; ra = bus.ramRdAdress;
    drive(1'b0, 8'h00, 1'b1); #2;
    n_cmp++; if (bus.ramRdEn !== 1'b0) begin n_bad++; $display("FAIL unf_rden got %b want 0", bus.ramRdEn); end
    tick();
    n_cmp++; if (bus.underflow !== 1'b1 || bus.popValid !== 1'b0) begin n_bad++; $display("FAIL unf_pulse got unf=%b vld=%b want 1 0", bus.underflow, bus.popValid); end
    n_cmp++; if (bus.ramWrAdress !== wa || bus.ramRdAdress !== ra) begin n_bad++; $display("FAIL unf_ptrs got wr=%0d rd=%0d want %0d %0d", bus.ramWrAdress, bus.ramRdAdress, wa, ra); end
    cycle(1'b0, 8'h00, 1'b0);
    n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL unf_once got %b want 0", bus.underflow); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'h41 + 8'(i), 1'b1);
      n_cmp++; if (bus.popValid !== 1'b1 || bus.popData !== 8'h40 + 8'(i)) begin n_bad++; $display("FAIL b2b_data got vld=%b data=%h want 1 %h", bus.popValid, bus.popData, 8'h40 + 8'(i)); end
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_cmp++; if (bus.popData !== 8'h68 || bus.count !== 5'd0) begin n_bad++; $display("FAIL b2b_last got data=%h count=%0d want 68 0", bus.popData, bus.count); end
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, 8'h70 + 8'(i), 1'b0);
      if (i == 2) begin
        n_cmp++; if (bus.almostEmpty !== ALM) begin n_bad++; $display("FAIL almost_empty2 got %b want %b", bus.almostEmpty, ALM); end
      end
      if (i == 3) begin
        n_cmp++; if (bus.almostEmpty !== 1'b0) begin n_bad++; $display("FAIL almost_empty3 got %b want 0", bus.almostEmpty); end
      end
      if (i == 13) begin
        n_cmp++; if (bus.almostFull !== 1'b0) begin n_bad++; $display("FAIL almost_full13 got %b want 0", bus.almostFull); end
      end
      if (i == 14) begin
        n_cmp++; if (bus.almostFull !== ALM) begin n_bad++; $display("FAIL almost_full14 got %b want %b", bus.almostFull, ALM); end
      end
    end
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    n_cmp++; if (bus.popValid !== 1'b1 || bus.count !== 5'd5) begin n_bad++; $display("FAIL rmid_pre got vld=%b count=%0d want 1 5", bus.popValid, bus.count); end
    mon_en = 1'b0;
    drive(1'b1, 8'h99, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.popValid !== 1'b0) begin n_bad++; $display("FAIL rmid_async got count=%0d empty=%b vld=%b want 0 1 0", bus.count, bus.empty, bus.popValid); end
    n_cmp++; if (bus.ramWrEn !== 1'b0) begin n_bad++; $display("FAIL rmid_wren got %b want 0", bus.ramWrEn); end
    exp_q.delete();
    m_count = 0; m_wp = 0; m_rp = 0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    drive(1'b1, 8'h3C, 1'b0); #2;
    n_cmp++; if (bus.ramWrAdress !== 4'd0) begin n_bad++; $display("FAIL rmid_wrptr got %0d want 0", bus.ramWrAdress); end
    tick();
    cycle(1'b0, 8'h00, 1'b1);
    n_cmp++; if (bus.popValid !== 1'b1 || bus.popData !== 8'h3C) begin n_bad++; $display("FAIL rmid_after got vld=%b data=%h want 1 3c", bus.popValid, bus.popData); end
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.pushEn = 1'b0; bus.pushData = '0; bus.popEn = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
